// File: rtl/truth_table_probe.sv
// Sweeps a 3-input logic block through all eight input rows, samples its output
// and reports the measured truth-table code, per-row instability and a match flag.
module truth_table_probe #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SAMPLES       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_code,
  output logic [7:0] unstable_mask,
  output logic       match
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ROW_W  = 3;
  localparam int unsigned CODE_W = 8;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(7);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [ROW_W-1:0]    r_row;
  logic [CNT_W-1:0]    r_cnt;
  logic [CODE_W-1:0]   r_expected;
  logic [CODE_W-1:0]   r_table;
  logic [CODE_W-1:0]   r_mask;
  logic                r_match;
  logic                r_busy;
  logic                r_done;
  logic [ROW_W-1:0]    r_drive;

  logic                w_accept;
  logic                w_settle_end;
  logic                w_sample_end;
  logic                w_last_row;
  logic [ROW_W-1:0]    w_bit;
  logic [ROW_W-1:0]    w_row_next;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_busy_d;
  logic                w_done_d;
  logic [ROW_W-1:0]    w_drive_d;

  assign w_accept     = (r_state == ST_IDLE) && start;
  assign w_settle_end = (r_cnt == SETTLE_LAST);
  assign w_sample_end = (r_cnt == SAMPLE_LAST);
  assign w_last_row   = (r_row == ROW_LAST);
  // Row i lands in code bit (7-i), i.e. the bitwise inverse of the row index.
  assign w_bit        = ~r_row;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (w_settle_end) begin
          w_next_state = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (w_sample_end) begin
          w_next_state = w_last_row ? ST_FINISH : ST_SETTLE;
        end
      end
      ST_FINISH: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Output / datapath next values, aligned so registered outputs track the state
  always_comb begin
    w_row_next = r_row;
    w_cnt_next = '0;
    w_busy_d   = 1'b0;
    w_done_d   = 1'b0;
    w_drive_d  = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_row_next = '0;
        end
      end
      ST_SAMPLE: begin
        if (w_sample_end && !w_last_row) begin
          w_row_next = r_row + ROW_W'(1);
        end
      end
      ST_FINISH: begin
        w_done_d = 1'b1;
      end
      default: begin
        w_row_next = r_row;
      end
    endcase

    // Counter restarts on every state change, including SAMPLE->SETTLE row steps.
    if ((w_next_state == ST_SETTLE) || (w_next_state == ST_SAMPLE)) begin
      w_busy_d  = 1'b1;
      w_drive_d = w_row_next;
      if (w_next_state == r_state) begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row      <= '0;
      r_cnt      <= '0;
      r_expected <= '0;
      r_table    <= '0;
      r_mask     <= '0;
      r_match    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_drive    <= '0;
    end else begin
      r_row   <= w_row_next;
      r_cnt   <= w_cnt_next;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_drive <= w_drive_d;

      if (w_accept) begin
        r_expected <= expected;
        r_table    <= '0;
        r_mask     <= '0;
        r_match    <= 1'b0;
      end else if (r_state == ST_SAMPLE) begin
        // First sample defines the row's bit; later disagreeing samples flag it.
        if (r_cnt == '0) begin
          r_table[w_bit] <= dut_out;
        end else if (dut_out != r_table[w_bit]) begin
          r_mask[w_bit] <= 1'b1;
        end
      end else if (r_state == ST_FINISH) begin
        r_match <= (r_table == r_expected) && (r_mask == '0);
      end
    end
  end

  assign in1           = r_drive[2];
  assign in2           = r_drive[1];
  assign in3           = r_drive[0];
  assign busy          = r_busy;
  assign done          = r_done;
  assign table_code    = r_table;
  assign unstable_mask = r_mask;
  assign match         = r_match;

endmodule

// File: tb/tb_truth_table_probe.sv
// Directed bench for truth_table_probe: default-parameter instance against a modelled
// 0x2E block (optionally unstable on row 011) and a 1/1 instance against a constant-1 block.
module tb_truth_table_probe;

  logic       clk;
  logic       rst;

  logic       start_a, start_b;
  logic [7:0] expected_a, expected_b;
  logic       dut_out_a, dut_out_b;
  logic       in1_a, in2_a, in3_a, in1_b, in2_b, in3_b;
  logic       busy_a, busy_b, done_a, done_b, match_a, match_b;
  logic [7:0] table_a, table_b, mask_a, mask_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_code = 8'h2E;
  bit         unstable_mode = 1'b0;
  int         cyc3 = 0;
  logic [2:0] row_a;

  truth_table_probe u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .expected(expected_a), .dut_out(dut_out_a),
    .in1(in1_a), .in2(in2_a), .in3(in3_a), .busy(busy_a), .done(done_a),
    .table_code(table_a), .unstable_mask(mask_a), .match(match_a)
  );

  truth_table_probe #(.SETTLE_CYCLES(1), .SAMPLES(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .expected(expected_b), .dut_out(dut_out_b),
    .in1(in1_b), .in2(in2_b), .in3(in3_b), .busy(busy_b), .done(done_b),
    .table_code(table_b), .unstable_mask(mask_b), .match(match_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign row_a     = {in1_a, in2_a, in3_a};
  assign dut_out_b = 1'b1;

  // Edges already spent on row 011; the unstable model toggles from the first sample on.
  always @(posedge clk) begin
    if (row_a == 3'd3) cyc3 <= cyc3 + 1;
    else               cyc3 <= 0;
  end

  always_comb begin
    dut_out_a = model_code[3'd7 - row_a];
    if (unstable_mode && (row_a == 3'd3)) begin
      dut_out_a = (cyc3 >= 4) ? 1'((cyc3 - 4) & 1) : 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start on one instance, scramble expected afterwards, report done edge offset.
  task automatic sweep(input bit sel_b, input logic [7:0] exp, input bit repulse,
                       output int done_at, output logic busy_first);
    @(negedge clk);
    if (sel_b) begin expected_b = exp; start_b = 1'b1; end
    else       begin expected_a = exp; start_a = 1'b1; end
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    expected_a = ~exp; expected_b = ~exp;
    busy_first = sel_b ? busy_b : busy_a;
    done_at = -1;
    for (int n = 1; n <= 200; n++) begin
      if (repulse && (n == 5 || n == 49)) start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      if (sel_b ? done_b : done_a) begin
        done_at = n;
        break;
      end
    end
  endtask

  // Count done pulses and busy cycles on instance A over a quiet window.
  task automatic watch_a(input int cycles, output int dones, output int busies);
    dones = 0; busies = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk); #1;
      if (done_a) dones++;
      if (busy_a) busies++;
    end
  endtask

  int   lat, nd, nb;
  logic bf;

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    expected_a = 8'h00; expected_b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  32'(busy_a), 32'd0);
    check("rst_done",  32'(done_a), 32'd0);
    check("rst_in",    32'({in1_a, in2_a, in3_a}), 32'd0);
    check("rst_table", 32'(table_a), 32'h00);
    check("rst_mask",  32'(mask_a), 32'h00);
    check("rst_match", 32'(match_a), 32'd0);
    check("rst_b_busy", 32'(busy_b), 32'd0);
    rst = 1'b0;

    // Stable 0x2E block, matching expectation
    sweep(1'b0, 8'h2E, 1'b0, lat, bf);
    check("m_lat",   32'(lat), 32'd49);
    check("m_busy1", 32'(bf), 32'd1);
    check("m_table", 32'(table_a), 32'h2E);
    check("m_mask",  32'(mask_a), 32'h00);
    check("m_match", 32'(match_a), 32'd1);
    check("m_idle_busy", 32'(busy_a), 32'd0);
    @(posedge clk); #1;
    check("m_done_pulse", 32'(done_a), 32'd0);
    check("m_hold_match", 32'(match_a), 32'd1);
    check("m_idle_in", 32'({in1_a, in2_a, in3_a}), 32'd0);

    // Mismatching expectation
    sweep(1'b0, 8'h2F, 1'b0, lat, bf);
    check("x_lat",   32'(lat), 32'd49);
    check("x_table", 32'(table_a), 32'h2E);
    check("x_match", 32'(match_a), 32'd0);

    // Row 011 toggles during sampling
    unstable_mode = 1'b1;
    sweep(1'b0, 8'h2E, 1'b0, lat, bf);
    check("u_lat",   32'(lat), 32'd49);
    check("u_table", 32'(table_a), 32'h2E);
    check("u_mask",  32'(mask_a), 32'h10);
    check("u_match", 32'(match_a), 32'd0);
    unstable_mode = 1'b0;

    // Start re-pulsed mid-sweep and during the finish cycle
    sweep(1'b0, 8'h2E, 1'b1, lat, bf);
    check("r_lat",   32'(lat), 32'd49);
    check("r_match", 32'(match_a), 32'd1);
    watch_a(60, nd, nb);
    check("r_extra_done", 32'(nd), 32'd0);
    check("r_idle_busy",  32'(nb), 32'd0);

    // Reset mid-sweep, with start held alongside reset
    @(negedge clk);
    expected_a = 8'h2E; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("a_busy_mid", 32'(busy_a), 32'd1);
    check("a_row_mid",  32'({in1_a, in2_a, in3_a}), 32'd3);
    rst = 1'b1; start_a = 1'b1;
    @(posedge clk); #1;
    check("a_busy",  32'(busy_a), 32'd0);
    check("a_in",    32'({in1_a, in2_a, in3_a}), 32'd0);
    check("a_table", 32'(table_a), 32'h00);
    check("a_done",  32'(done_a), 32'd0);
    rst = 1'b0; start_a = 1'b0;
    watch_a(60, nd, nb);
    check("a_no_done", 32'(nd), 32'd0);
    check("a_no_busy", 32'(nb), 32'd0);
    sweep(1'b0, 8'h2E, 1'b0, lat, bf);
    check("a_re_lat",   32'(lat), 32'd49);
    check("a_re_table", 32'(table_a), 32'h2E);
    check("a_re_match", 32'(match_a), 32'd1);

    // Minimal timing instance, constant-1 block
    sweep(1'b1, 8'hFF, 1'b0, lat, bf);
    check("b_lat",   32'(lat), 32'd17);
    check("b_table", 32'(table_b), 32'hFF);
    check("b_mask",  32'(mask_b), 32'h00);
    check("b_match", 32'(match_b), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_probe.md
TRUTH_TABLE_PROBE -- requirements
Module: truth_table_probe

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: cycles the inputs are held before sampling starts (legal range 1..255).
REQ-002 Parameter SAMPLES, default 2: consecutive samples of dut_out taken per input row (legal range 1..15).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to characterise the attached 3-input logic block.
REQ-006 expected  input  8  truth-table code to compare against; sampled only on an accepted start.
REQ-007 dut_out  input  1  output of the 3-input logic block under test.
REQ-008 in1, in2, in3  output  1 each  drive to the block under test; in1 is the MSB of the row index.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse when a sweep completes.
REQ-011 table_code  output  8  measured truth-table code.
REQ-012 unstable_mask  output  8  bit set where the samples for that row disagreed.
REQ-013 match  output  1  measured code equals the captured expected code and unstable_mask is zero.

Function
REQ-014 Row mapping: row i = {in1,in2,in3} = i (0..7); dut_out for row i is stored in table_code bit (7-i), so row 000 maps to bit 7 and row 111 to bit 0.
REQ-015 FSM states: IDLE, SETTLE, SAMPLE, FINISH.
REQ-016 IDLE: busy=0; a start accepted at a clock edge loads row=0, captures expected, clears table_code, unstable_mask and match, and moves to SETTLE.
REQ-017 SETTLE: busy=1; in1..in3 drive the current row; stays exactly SETTLE_CYCLES cycles, then moves to SAMPLE.
REQ-018 SAMPLE: samples dut_out on each of SAMPLES consecutive cycles. The first sample is written into the row's table_code bit. Any later sample that differs from the first sets the row's unstable_mask bit.
REQ-019 After the last sample of a row: if row<7, increment the row and go to SETTLE; if row=7, go to FINISH.
REQ-020 FINISH lasts one cycle: done=1, match updated, busy=0, then IDLE.
REQ-021 Latency: with start accepted at edge k, done is high in the cycle following edge k+8*(SETTLE_CYCLES+SAMPLES)+1. With defaults, that is edge k+49.
REQ-022 The row counter is 3 bits and never wraps within a sweep; row 7 always terminates the sweep.
REQ-023 start while busy=1 (including the FINISH cycle) is ignored and SHALL NOT restart or extend the sweep.
REQ-024 table_code, unstable_mask and match hold their last values in IDLE until the next accepted start.
REQ-025 in1..in3 drive 000 whenever the state is IDLE or FINISH.
REQ-026 expected changes after acceptance of start SHALL NOT affect match.
REQ-027 dut_out is treated as synchronous; the block adds no synchroniser.

Reset
REQ-028 Reset with rst high at an edge: state=IDLE; busy=0, done=0, in1..in3=000, table_code=0x00, unstable_mask=0x00, match=0, internal counters=0.
REQ-029 rst has priority over start and over any in-progress sweep; a sweep aborted by reset produces no done pulse.
REQ-030 start asserted in the same cycle as rst is ignored.

Verification
REQ-031 Defaults, bench models a block with code 0x2E (rows 000..111 give 0,0,1,0,1,1,1,0), expected=0x2E, pulse start -> done at edge k+49, table_code=0x2E, unstable_mask=0x00, match=1.
REQ-032 Same model, expected=0x2F -> table_code=0x2E, match=0.
REQ-033 Model output toggles every cycle during row 011 sampling (first sample 0, SAMPLES=2) -> table_code bit 4=0, unstable_mask=0x10, match=0 even with expected=0x2E.
REQ-034 start re-pulsed at edges k+5 and k+49 -> exactly one done, at edge k+49; busy never re-asserts in IDLE without a new start.
REQ-035 rst asserted at edge k+20 mid-sweep -> next cycle busy=0, in1..in3=000, table_code=0x00, and no done pulse; a new start then completes normally.
REQ-036 SETTLE_CYCLES=1, SAMPLES=1, constant-1 model, expected=0xFF -> done at edge k+17, table_code=0xFF, match=1.
